// File: rtl/generador_tubos.sv
// generador_tubos: scrolls one pipe left per frame, respawns it with a pseudo-random gap, counts pipes passed
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   frame_tick   one-cycle pulse per video frame
//   start        one-cycle pulse: begin or restart the game
//   choque       collision level from the comparator
//   tubox/tuboy  registered pipe left edge and gap top
//   activo       high while running
//   paso         one-cycle pulse when the pipe passes the bird
//   puntaje      saturating count of pipes passed
module generador_tubos #(
  parameter int START_X = 640,
  parameter int STEP = 2,
  parameter int PIPE_W = 60,
  parameter int BIRD_X = 160,
  parameter int GAP_MIN = 60,
  parameter logic [7:0] GAP_MASK = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       choque,
  output logic [9:0] tubox,
  output logic [9:0] tuboy,
  output logic       activo,
  output logic       paso,
  output logic [7:0] puntaje
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] CRASH = 2'd2;
  localparam logic [9:0] SX = 10'(START_X);
  localparam logic [9:0] ST = 10'(STEP);
  localparam logic [9:0] GM = 10'(GAP_MIN);
  localparam logic [10:0] PW = 11'(PIPE_W);
  localparam logic [10:0] BX = 11'(BIRD_X);
  localparam logic [10:0] ST11 = 11'(STEP);
  logic [1:0] state, state_n;
  logic [7:0] lfsr;
  logic [10:0] x_pw, xn_pw;
  logic run_tick, restart, load, move, score;
  // right-edge positions before and after the move, 11 bits so nothing wraps
  assign x_pw = {1'b0, tubox} + PW;
  assign xn_pw = {1'b0, tubox} - ST11 + PW;
  // a collision wins over a same-cycle frame tick
  assign run_tick = state == RUN && !choque && frame_tick;
  assign restart = state != RUN && start;
  assign load = restart || (run_tick && tubox < ST);
  assign move = run_tick && tubox >= ST;
  assign score = move && x_pw > BX && xn_pw <= BX;
  always_comb begin
    state_n = restart ? RUN : (state == RUN && choque) ? CRASH : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tubox <= SX;
      tuboy <= GM;
      activo <= 1'b0;
      paso <= 1'b0;
      puntaje <= 8'd0;
      lfsr <= 8'hA5;
    end else begin
      state <= state_n;
      activo <= state_n == RUN;
      paso <= score;
      if (load) begin
        tubox <= SX;
        tuboy <= GM + {2'b0, lfsr & GAP_MASK};
        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end else if (move) tubox <= tubox - ST;
      if (restart) puntaje <= 8'd0;
      else if (score && puntaje != 8'hFF) puntaje <= puntaje + 8'd1;
    end
  end
endmodule

// File: tb/tb_generador_tubos.sv
// tb_generador_tubos: model-based and directed checks for generador_tubos
module tb_generador_tubos;
  logic clk = 0, rst_n = 0, frame_tick = 0, start = 0, choque = 0;
  logic [9:0] tubox, tuboy;
  logic activo, paso;
  logic [7:0] puntaje;
  int passed = 0, total = 0;
  int m_state, m_x, m_y, m_score;
  bit m_paso;
  logic [7:0] m_lfsr;
  generador_tubos dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start), .choque(choque),
    .tubox(tubox), .tuboy(tuboy), .activo(activo), .paso(paso), .puntaje(puntaje)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction
  // model: 0 idle, 1 running, 2 crashed
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_x = 640; m_y = 60; m_lfsr = 8'hA5; m_score = 0; m_paso = 0;
    end else begin
      m_paso = 0;
      if (m_state != 1) begin
        if (start) begin
          m_x = 640; m_y = 60 + m_lfsr; m_lfsr = lfsr_next(m_lfsr); m_score = 0; m_state = 1;
        end
      end else if (choque) m_state = 2;
      else if (frame_tick) begin
        if (m_x < 2) begin
          m_x = 640; m_y = 60 + m_lfsr; m_lfsr = lfsr_next(m_lfsr);
        end else begin
          if (m_x + 60 > 160 && m_x - 2 + 60 <= 160) begin
            m_paso = 1;
            if (m_score < 255) m_score++;
          end
          m_x -= 2;
        end
      end
    end
  end
  always @(negedge clk) begin
    check("model_tubox", tubox, m_x);
    check("model_tuboy", tuboy, m_y);
    check("model_activo", activo, m_state == 1);
    check("model_paso", paso, m_paso);
    check("model_puntaje", puntaje, m_score);
  end
  task automatic cyc(input bit fr, input bit st, input bit ch);
    frame_tick = fr; start = st; choque = ch;
    @(negedge clk);
    frame_tick = 0; start = 0; choque = 0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("reset_tubox", tubox, 640);
    check("reset_tuboy", tuboy, 60);
    check("reset_activo", activo, 0);
    check("reset_paso", paso, 0);
    check("reset_puntaje", puntaje, 0);
    rst_n = 1;
    cyc(1, 0, 1);
    check("idle_ignores_tick", tubox, 640);
    check("idle_activo", activo, 0);
    cyc(0, 1, 0);
    check("start_activo", activo, 1);
    check("start_tubox", tubox, 640);
    check("start_tuboy", tuboy, 225);
    check("start_lfsr", dut.lfsr, 8'h4A);
    for (int i = 1; i <= 270; i++) begin
      cyc(1, 0, 0);
      check("scroll_paso", paso, i == 270);
      cyc(0, 0, 0);
    end
    check("scroll_tubox", tubox, 100);
    check("scroll_puntaje", puntaje, 1);
    repeat (50) cyc(1, 0, 0);
    check("edge_tubox", tubox, 0);
    cyc(1, 0, 0);
    check("respawn_tubox", tubox, 640);
    check("respawn_tuboy", tuboy, 134);
    check("respawn_paso", paso, 0);
    repeat (70) cyc(1, 0, 0);
    check("pre_crash_tubox", tubox, 500);
    cyc(0, 1, 0);
    check("run_ignores_start", tubox, 500);
    check("run_ignores_start_y", tuboy, 134);
    cyc(1, 0, 1);
    check("crash_tubox", tubox, 500);
    check("crash_activo", activo, 0);
    cyc(1, 0, 1);
    repeat (3) cyc(1, 0, 0);
    check("crash_frozen", tubox, 500);
    check("crash_puntaje", puntaje, 1);
    cyc(0, 1, 0);
    check("restart_tubox", tubox, 640);
    check("restart_tuboy", tuboy, 209);
    check("restart_puntaje", puntaje, 0);
    check("restart_activo", activo, 1);
    repeat (3) cyc(1, 0, 0);
    check("rerun_tubox", tubox, 634);
    #2 rst_n = 0;
    #1;
    check("async_tubox", tubox, 640);
    check("async_tuboy", tuboy, 60);
    check("async_activo", activo, 0);
    check("async_puntaje", puntaje, 0);
    check("async_paso", paso, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
